// File: rtl/rv_scoreboard.sv
// Issue-side interlock: tracks destination registers of in-flight long-latency
// operations and holds decode while a source or destination is still pending.
module rv_scoreboard #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_issue_valid,
  output logic       o_issue_ready,
  input  logic [4:0] i_issue_rs1,
  input  logic [4:0] i_issue_rs2,
  input  logic       i_issue_rs1_used,
  input  logic       i_issue_rs2_used,
  input  logic [4:0] i_issue_rd,
  input  logic       i_issue_reg_write,
  input  logic       i_issue_long,
  input  logic       i_flush,
  input  logic       i_done_valid,
  input  logic [4:0] i_done_rd,
  output logic       o_stall_rs1,
  output logic       o_stall_rs2,
  output logic       o_stall_waw,
  output logic       o_busy,
  output logic [3:0] o_outstanding,
  output logic       o_err
);

  // Handshake: an instruction transfers in a cycle where i_issue_valid and
  // o_issue_ready are both high; ready never depends on anything registered
  // later than the current cycle, and valid may be held across stalled cycles.

  logic [31:0] pending_q, pending_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [31:0] clr_vec;
  logic [31:0] eff_pending;
  logic        long_tracked;
  logic        done_ok;
  logic        full;
  logic        accept_long;

  // A completing register is forwarded from write-back, so it no longer blocks.
  assign clr_vec      = (i_done_valid && (i_done_rd != 5'd0)) ? (32'd1 << i_done_rd) : 32'd0;
  assign eff_pending  = pending_q & ~clr_vec;

  assign o_stall_rs1  = i_issue_valid & i_issue_rs1_used  & eff_pending[i_issue_rs1];
  assign o_stall_rs2  = i_issue_valid & i_issue_rs2_used  & eff_pending[i_issue_rs2];
  assign o_stall_waw  = i_issue_valid & i_issue_reg_write & eff_pending[i_issue_rd];

  assign long_tracked = i_issue_long & i_issue_reg_write & (i_issue_rd != 5'd0);
  assign done_ok      = i_done_valid & (i_done_rd != 5'd0) & pending_q[i_done_rd];
  // Only a genuine release frees a slot, so the counter can never exceed its cap.
  assign full         = (count_q == 4'(MAX_OUTSTANDING)) & ~done_ok;

  assign o_issue_ready = ~i_reset & ~i_flush & ~o_stall_rs1 & ~o_stall_rs2
                       & ~o_stall_waw & ~(full & long_tracked);

  assign accept_long  = i_issue_valid & o_issue_ready & long_tracked;

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    err_d     = err_q;
    if (done_ok) begin
      pending_d[i_done_rd] = 1'b0;
    end else if (i_done_valid) begin
      err_d = 1'b1;
    end
    // Set after clear so a same-register re-issue keeps the bit.
    if (accept_long) begin
      pending_d[i_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
    count_d      = count_q + {3'b000, accept_long} - {3'b000, done_ok};
    busy_d       = (count_d != 4'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending_q <= 32'd0;
      count_q   <= 4'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_outstanding = count_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Bench for rv_scoreboard: directed hazard scenarios plus random traffic,
// checked against a behavioural model through an expected-output queue.
module tb_rv_scoreboard;

  logic       i_clk;
  logic       i_reset;
  logic       i_issue_valid;
  logic       o_issue_ready;
  logic [4:0] i_issue_rs1, i_issue_rs2, i_issue_rd, i_done_rd;
  logic       i_issue_rs1_used, i_issue_rs2_used;
  logic       i_issue_reg_write, i_issue_long, i_flush, i_done_valid;
  logic       o_stall_rs1, o_stall_rs2, o_stall_waw, o_busy, o_err;
  logic [3:0] o_outstanding;

  rv_scoreboard #(.MAX_OUTSTANDING(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .i_issue_rs1_used(i_issue_rs1_used), .i_issue_rs2_used(i_issue_rs2_used),
    .i_issue_rd(i_issue_rd), .i_issue_reg_write(i_issue_reg_write),
    .i_issue_long(i_issue_long), .i_flush(i_flush),
    .i_done_valid(i_done_valid), .i_done_rd(i_done_rd),
    .o_stall_rs1(o_stall_rs1), .o_stall_rs2(o_stall_rs2), .o_stall_waw(o_stall_waw),
    .o_busy(o_busy), .o_outstanding(o_outstanding), .o_err(o_err)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // {ready, stall_rs1, stall_rs2, stall_waw, busy, outstanding[3:0], err}
  logic [9:0] exp_q[$];

  // reference model state
  logic [31:0] m_pend;
  int          m_cnt;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic lng, input logic fl,
                       input logic dv, input logic [4:0] drd);
    i_issue_valid = v;  i_issue_rs1 = rs1; i_issue_rs1_used = u1;
    i_issue_rs2 = rs2;  i_issue_rs2_used = u2; i_issue_rd = rd;
    i_issue_reg_write = wr; i_issue_long = lng; i_flush = fl;
    i_done_valid = dv; i_done_rd = drd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic eff(input logic [4:0] r);
    return m_pend[r] & ~(i_done_valid & (i_done_rd == r) & (r != 0));
  endfunction

  // One cycle: predict outputs, compare at negedge, advance model at posedge.
  task automatic step();
    logic s1, s2, sw, lt, full, rdy, ok;
    logic [9:0] e, o;
    s1   = i_issue_valid & i_issue_rs1_used & eff(i_issue_rs1);
    s2   = i_issue_valid & i_issue_rs2_used & eff(i_issue_rs2);
    sw   = i_issue_valid & i_issue_reg_write & eff(i_issue_rd);
    lt   = i_issue_long & i_issue_reg_write & (i_issue_rd != 0);
    full = (m_cnt == 2) & ~i_done_valid;
    rdy  = ~i_reset & ~i_flush & ~s1 & ~s2 & ~sw & ~(full & lt);
    exp_q.push_back({rdy, s1, s2, sw, (m_cnt != 0), 4'(m_cnt), m_err});
    @(negedge i_clk);
    e = exp_q.pop_front();
    o = {o_issue_ready, o_stall_rs1, o_stall_rs2, o_stall_waw, o_busy, o_outstanding, o_err};
    check("ready", 32'(o[9]), 32'(e[9]));
    check("stall_rs1", 32'(o[8]), 32'(e[8]));
    check("stall_rs2", 32'(o[7]), 32'(e[7]));
    check("stall_waw", 32'(o[6]), 32'(e[6]));
    check("busy", 32'(o[5]), 32'(e[5]));
    check("outstanding", 32'(o[4:1]), 32'(e[4:1]));
    check("err", 32'(o[0]), 32'(e[0]));
    if (i_reset) begin
      m_pend = 0; m_cnt = 0; m_err = 0;
    end else begin
      ok = i_done_valid & (i_done_rd != 0) & m_pend[i_done_rd];
      if (ok) begin
        m_pend[i_done_rd] = 1'b0; m_cnt--;
      end else if (i_done_valid) begin
        m_err = 1'b1;
      end
      if (i_issue_valid & rdy & lt) begin
        m_pend[i_issue_rd] = 1'b1; m_cnt++;
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; idle();
    step(); step();
    i_reset = 1'b0;
  endtask

  initial begin
    m_pend = 0; m_cnt = 0; m_err = 0;
    i_reset = 1'b1; idle();
    @(posedge i_clk); #1;
    do_reset();
    check("rst_outstanding", 32'(o_outstanding), 0);
    check("rst_err", 32'(o_err), 0);

    // plain ALU ops never tracked
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); step();
    end
    check("alu_busy", 32'(o_busy), 0);

    // lw x5 then dependent add, released by completion in cycle 4
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); step();
    for (int i = 1; i < 4; i++) begin
      drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0); step();
    end
    check("dep_pending_out", 32'(o_outstanding), 1);
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 5); step();
    check("dep_released_out", 32'(o_outstanding), 0);

    // capacity: two loads fill, third held until a completion
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 6, 1, 1, 0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 5); step();
    check("full_swap_out", 32'(o_outstanding), 2);
    idle(); i_done_valid = 1; i_done_rd = 6; step();
    i_done_rd = 7; step();

    // WAW on x5, then completion plus re-issue in the same cycle
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); step();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 1, 5); step();
    check("waw_reissue_out", 32'(o_outstanding), 1);
    drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 0, 0); step();
    idle(); i_done_valid = 1; i_done_rd = 5; step();

    // flush keeps pending x8; completion later clears it cleanly
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0, 0); step();
    drive(1, 2, 1, 3, 1, 4, 1, 0, 1, 0, 0); step();
    drive(1, 8, 1, 0, 0, 4, 1, 0, 0, 0, 0); step();
    idle(); i_done_valid = 1; i_done_rd = 8; step();
    idle(); step();
    check("flush_err", 32'(o_err), 0);

    // random traffic; completions only target pending registers
    for (int n = 0; n < 300; n++) begin
      logic [4:0] drd;
      logic       dv;
      dv = 1'b0; drd = 5'd0;
      if (m_pend != 0 && $urandom_range(0, 2) == 0) begin
        do drd = 5'($urandom_range(1, 31)); while (!m_pend[drd]);
        dv = 1'b1;
      end
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0), dv, drd);
      step();
    end

    // drain, then a completion for a never-issued register
    do_reset();
    idle(); i_done_valid = 1; i_done_rd = 9; step();
    idle(); step(); step();
    check("err_sticky", 32'(o_err), 1);
    check("err_out", 32'(o_outstanding), 0);
    do_reset();
    check("err_cleared", 32'(o_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
